// File: rtl/upsample_sequencer.sv
// Frame-level controller for the upsample convolution layer: streams weights from
// a synchronous memory into the layer, then walks the frame pixel by pixel.
module upsample_sequencer #(
  parameter int IN_CHANNELS       = 3,
  parameter int OUT_CHANNELS      = 12,
  parameter int KERNEL_SIZE       = 3,
  parameter int DATA_WIDTH        = 16,
  parameter int WEIGHT_ADDR_WIDTH = 20,
  parameter int IMG_W             = 64,
  parameter int IMG_H             = 48,
  parameter int TIMEOUT           = 2048
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output logic                                 wmem_rd,
  output logic [WEIGHT_ADDR_WIDTH-1:0]         wmem_addr,
  input  logic [DATA_WIDTH-1:0]                wmem_data,
  output logic                                 load_weights,
  output logic [WEIGHT_ADDR_WIDTH-1:0]         weight_addr,
  output logic [DATA_WIDTH-1:0]                weight_in,
  output logic                                 start_conv,
  input  logic                                 conv_done,
  output logic [IN_CHANNELS*DATA_WIDTH-1:0]    layer_pixel,
  input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]   layer_result,
  input  logic                                 pix_valid,
  output logic                                 pix_ready,
  input  logic [IN_CHANNELS*DATA_WIDTH-1:0]    pix_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [OUT_CHANNELS*DATA_WIDTH-1:0]   out_data,
  output logic                                 out_last
);

  localparam int KK  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NW  = IN_CHANNELS * OUT_CHANNELS * KK + OUT_CHANNELS;
  localparam int PW  = IN_CHANNELS * DATA_WIDTH;
  localparam int RW  = OUT_CHANNELS * DATA_WIDTH;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int XW  = $clog2(IMG_W + 1);
  localparam int YW  = $clog2(IMG_H + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_GET_PIX,
    S_START,
    S_WAIT_CLR,
    S_WAIT_DONE,
    S_EMIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t                         r_state;
  state_t                         w_next_state;
  logic [WEIGHT_ADDR_WIDTH-1:0]   r_load_cnt;
  logic [WDW-1:0]                 r_wd_cnt;
  logic [XW-1:0]                  r_x;
  logic [YW-1:0]                  r_y;
  logic [PW-1:0]                  r_layer_pixel;
  logic [RW-1:0]                  r_out_data;
  logic                           r_error;

  logic w_load_last;
  logic w_timeout;
  logic w_last_pix;
  logic w_start_accept;
  logic w_pix_hs;
  logic w_out_hs;
  logic w_capture;
  logic w_timeout_hit;

  // r_load_cnt counts NW read cycles plus one trailing write cycle for the last word.
  assign w_load_last = (r_load_cnt == WEIGHT_ADDR_WIDTH'(NW));
  assign w_timeout   = (r_wd_cnt == WDW'(TIMEOUT - 1));
  assign w_last_pix  = (r_x == XW'(IMG_W - 1)) && (r_y == YW'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: every clocked register uses <= so all flops update from pre-edge values.
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case infers a latch.
    w_next_state   = r_state;
    busy           = 1'b0;
    done           = 1'b0;
    wmem_rd        = 1'b0;
    wmem_addr      = '0;
    load_weights   = 1'b0;
    weight_addr    = '0;
    weight_in      = '0;
    start_conv     = 1'b0;
    pix_ready      = 1'b0;
    out_valid      = 1'b0;
    out_last       = 1'b0;
    w_start_accept = 1'b0;
    w_pix_hs       = 1'b0;
    w_out_hs       = 1'b0;
    w_capture      = 1'b0;
    w_timeout_hit  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_accept = 1'b1;
          w_next_state   = S_LOAD;
        end
      end

      S_LOAD: begin
        busy = 1'b1;
        if (!w_load_last) begin
          wmem_rd   = 1'b1;
          wmem_addr = r_load_cnt;
        end
        // Memory data lags the read by one cycle, so the write trails the address by one.
        if (r_load_cnt != '0) begin
          load_weights = 1'b1;
          weight_addr  = r_load_cnt - WEIGHT_ADDR_WIDTH'(1);
          weight_in    = wmem_data;
        end
        if (w_load_last) begin
          w_next_state = S_GET_PIX;
        end
      end

      S_GET_PIX: begin
        busy      = 1'b1;
        pix_ready = 1'b1;
        if (pix_valid) begin
          w_pix_hs     = 1'b1;
          w_next_state = S_START;
        end
      end

      S_START: begin
        busy         = 1'b1;
        start_conv   = 1'b1;
        w_next_state = S_WAIT_CLR;
      end

      S_WAIT_CLR: begin
        busy = 1'b1;
        if (!conv_done) begin
          w_next_state = S_WAIT_DONE;
        end else if (w_timeout) begin
          w_timeout_hit = 1'b1;
          w_next_state  = S_ERR;
        end
      end

      S_WAIT_DONE: begin
        busy = 1'b1;
        if (conv_done) begin
          w_capture    = 1'b1;
          w_next_state = S_EMIT;
        end else if (w_timeout) begin
          w_timeout_hit = 1'b1;
          w_next_state  = S_ERR;
        end
      end

      S_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = w_last_pix;
        if (out_ready) begin
          w_out_hs     = 1'b1;
          w_next_state = w_last_pix ? S_DONE : S_GET_PIX;
        end
      end

      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_start_accept = 1'b1;
          w_next_state   = S_LOAD;
        end else begin
          w_next_state = S_IDLE;
        end
      end

      S_ERR: begin
        if (start) begin
          w_start_accept = 1'b1;
          w_next_state   = S_LOAD;
        end
      end

      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_cnt    <= '0;
      r_wd_cnt      <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_layer_pixel <= '0;
      r_out_data    <= '0;
      r_error       <= 1'b0;
    end else begin
      if (w_start_accept) begin
        r_load_cnt <= '0;
        r_x        <= '0;
        r_y        <= '0;
        r_error    <= 1'b0;
      end else begin
        if (r_state == S_LOAD) begin
          r_load_cnt <= r_load_cnt + WEIGHT_ADDR_WIDTH'(1);
        end
        if (w_timeout_hit) begin
          r_error <= 1'b1;
        end
        if (w_out_hs) begin
          if (r_x == XW'(IMG_W - 1)) begin
            r_x <= '0;
            r_y <= r_y + YW'(1);
          end else begin
            r_x <= r_x + XW'(1);
          end
        end
      end

      // The watchdog window opens on the start_conv cycle and spans both wait states.
      if (r_state == S_START) begin
        r_wd_cnt <= '0;
      end else if (r_state == S_WAIT_CLR || r_state == S_WAIT_DONE) begin
        r_wd_cnt <= r_wd_cnt + WDW'(1);
      end

      if (w_pix_hs) begin
        r_layer_pixel <= pix_data;
      end
      if (w_capture) begin
        r_out_data <= layer_result;
      end
    end
  end

  assign error       = r_error;
  assign layer_pixel = r_layer_pixel;
  assign out_data    = r_out_data;

endmodule
